// File: rtl/mem_stage_port_pkg.sv
// mem_stage_port_pkg: staging packet, bank geometry, FSM states and slice helpers
package mem_stage_port_pkg;
    localparam int BANK_DEPTH      = 140;
    localparam int BANK_ADDR_WIDTH = 8;
    localparam int MAX_COLS        = 140;
    localparam int TX_DATA_WIDTH   = 32;
    localparam int COL_ADDR_WIDTH  = 8;

    typedef logic [MAX_COLS-1:0] row_t;

    typedef struct packed {
        logic                       staging;
        logic                       read_en;
        logic                       write_en;
        logic [BANK_ADDR_WIDTH-1:0] row_addr;
        logic [COL_ADDR_WIDTH-1:0]  col_addr;
        logic [TX_DATA_WIDTH-1:0]   partial_vec;
    } tb_packet_t;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_COMMIT, CAPTURE, ACK, DROP} stage_state_e;

    // Shifting within a row-wide value truncates at MAX_COLS, so a straddling slice never wraps.
    function automatic row_t merge_slice(row_t row, logic [COL_ADDR_WIDTH-1:0] col, logic [TX_DATA_WIDTH-1:0] vec);
        return (row & ~(row_t'({TX_DATA_WIDTH{1'b1}}) << col)) | (row_t'(vec) << col);
    endfunction

    function automatic logic [TX_DATA_WIDTH-1:0] extract_slice(row_t row, logic [COL_ADDR_WIDTH-1:0] col);
        return TX_DATA_WIDTH'(row >> col);
    endfunction

    function automatic logic bad_request(logic rd, logic wr, logic [BANK_ADDR_WIDTH-1:0] row, logic [COL_ADDR_WIDTH-1:0] col);
        return (rd & wr) | (int'(row) >= BANK_DEPTH) | (int'(col) >= MAX_COLS);
    endfunction
endpackage

// File: rtl/mem_stage_port_if.sv
// mem_stage_port_if: host staging request and busy/ack completion signals
interface mem_stage_port_if import mem_stage_port_pkg::*; ();
    logic                     pad_en;
    tb_packet_t               tb_packet_in;
    logic                     mem_ack_out;
    logic                     mem_busy_out;
    logic [TX_DATA_WIDTH-1:0] rd_vec_out;
    logic                     err_out;

    modport master (output pad_en, tb_packet_in, input mem_ack_out, mem_busy_out, rd_vec_out, err_out);
    modport slave  (input pad_en, tb_packet_in, output mem_ack_out, mem_busy_out, rd_vec_out, err_out);
endinterface

// File: rtl/mem_stage_port_bank_ram.sv
// bank_ram: one row per word, synchronous write-first read with one cycle of latency
module bank_ram import mem_stage_port_pkg::*; (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [BANK_ADDR_WIDTH-1:0] addr,
    input  row_t                       wdata,
    output row_t                       rdata
);
    row_t mem [BANK_DEPTH];

    always_ff @(posedge clk)
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= we ? wdata : mem[addr];
        end
endmodule

// File: rtl/mem_stage_port.sv
// mem_stage_port: host slice read/read-modify-write into the main bank with busy/ack handshake
module mem_stage_port import mem_stage_port_pkg::*; (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_stage_port_if.slave            host,
    input  logic                       mach_en,
    input  logic                       mach_we,
    input  logic [BANK_ADDR_WIDTH-1:0] mach_addr,
    input  row_t                       mach_wdata,
    output row_t                       mach_rdata,
    output logic                       bank_sel
);
    stage_state_e               state, next;
    tb_packet_t                 pkt;
    logic                       req, bad, wr_q, err_q;
    logic [BANK_ADDR_WIDTH-1:0] row_q;
    logic [COL_ADDR_WIDTH-1:0]  col_q;
    logic [TX_DATA_WIDTH-1:0]   vec_q, rd_vec_q;
    row_t                       rdata;

    assign pkt = host.tb_packet_in;
    assign req = host.pad_en & pkt.staging & (pkt.read_en | pkt.write_en);
    assign bad = bad_request(pkt.read_en, pkt.write_en, pkt.row_addr, pkt.col_addr);

    always_comb begin
        next = state;
        case (state)
            IDLE:               next = req ? (bad ? ACK : RD_ISSUE) : IDLE;
            RD_ISSUE:           next = RD_WAIT;
            RD_WAIT:            next = wr_q ? WR_COMMIT : CAPTURE;
            WR_COMMIT, CAPTURE: next = ACK;
            ACK:                next = (pkt.read_en | pkt.write_en) ? ACK : DROP;
            default:            next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state    <= IDLE;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            vec_q    <= '0;
            rd_vec_q <= '0;
        end else begin
            state <= next;
            if (state == IDLE && req) begin
                wr_q     <= pkt.write_en;
                err_q    <= bad;
                row_q    <= pkt.row_addr;
                col_q    <= pkt.col_addr;
                vec_q    <= pkt.partial_vec;
                rd_vec_q <= '0;
            end
            if (state == CAPTURE) rd_vec_q <= extract_slice(rdata, col_q);
            if (next == IDLE) err_q <= 1'b0;
        end

    // Host keeps the bank while staging in IDLE or while any transfer is in flight.
    assign bank_sel = (state != IDLE) | pkt.staging;

    bank_ram u_bank (
        .clk   (clk),
        .en    (bank_sel ? (state == RD_ISSUE || state == WR_COMMIT) : mach_en),
        .we    (bank_sel ? (state == WR_COMMIT) : mach_we),
        .addr  (bank_sel ? row_q : mach_addr),
        .wdata (bank_sel ? merge_slice(rdata, col_q, vec_q) : mach_wdata),
        .rdata (rdata)
    );

    assign mach_rdata        = rdata;
    assign host.mem_ack_out  = state == ACK;
    assign host.mem_busy_out = state != IDLE;
    assign host.rd_vec_out   = rd_vec_q;
    assign host.err_out      = err_q;
endmodule
